// File: rtl/vga_timing_pkg.sv
// Shared raster geometry for the VGA timing generator and the overlay stages.
// Holds the 640x480@60 defaults, derived totals, sync windows and overlay windows.
package vga_timing_pkg;

   localparam int CNT_W = 10;

   localparam int H_ACTIVE_D = 640;
   localparam int H_FP_D     = 16;
   localparam int H_SYNC_D   = 96;
   localparam int H_BP_D     = 48;
   localparam int V_ACTIVE_D = 480;
   localparam int V_FP_D     = 10;
   localparam int V_SYNC_D   = 2;
   localparam int V_BP_D     = 33;

   localparam int H_TOTAL_D = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
   localparam int V_TOTAL_D = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

   // Sync windows are half-open: [START, END)
   localparam int H_SYNC_START_D = H_ACTIVE_D + H_FP_D;
   localparam int H_SYNC_END_D   = H_SYNC_START_D + H_SYNC_D;
   localparam int V_SYNC_START_D = V_ACTIVE_D + V_FP_D;
   localparam int V_SYNC_END_D   = V_SYNC_START_D + V_SYNC_D;

   // Overlay windows, shared so every overlay decodes the same geometry
   localparam int EMBLEM_X0 = 256;
   localparam int EMBLEM_Y0 = 176;
   localparam int EMBLEM_W  = 128;
   localparam int EMBLEM_H  = 128;
   localparam int TEXT_X0   = 64;
   localparam int TEXT_Y0   = 400;
   localparam int TEXT_W    = 512;
   localparam int TEXT_H    = 16;

   typedef logic [CNT_W-1:0] coord_t;

   // Unsigned half-open window test: lo <= v < hi
   function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/vga_timing_gen_counter.sv
// Modulo counter with increment enable and wrap indication.
// o_next exposes the value the counter will hold after the coming edge so the
// parent can register decodes that line up with the count.
module mod_counter #(
   parameter int WIDTH     = 10,
   parameter int MODULUS   = 800,
   parameter int RESET_VAL = MODULUS - 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count,
   output logic [WIDTH-1:0] o_next,
   output logic             o_wrap
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RST  = WIDTH'(RESET_VAL);

   logic [WIDTH-1:0] r_count;

   // Next-state and wrap decode from the current count
   always_comb begin
      o_wrap = i_inc && (r_count == LAST);
      o_next = r_count;
      if (i_inc) begin
         o_next = o_wrap ? '0 : r_count + WIDTH'(1);
      end
   end

   // Count register, async reset to the preload value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= RST;
      end else begin
         r_count <= o_next;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator.
// Counters start at the last raster position so the first edge after reset
// lands on (0,0) with a clean frame_start. All flags are registered decodes of
// the next (h,v), so they are cycle-aligned with x/y.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE    = H_ACTIVE_D,
   parameter int   H_FP        = H_FP_D,
   parameter int   H_SYNC      = H_SYNC_D,
   parameter int   H_BP        = H_BP_D,
   parameter int   V_ACTIVE    = V_ACTIVE_D,
   parameter int   V_FP        = V_FP_D,
   parameter int   V_SYNC      = V_SYNC_D,
   parameter int   V_BP        = V_BP_D,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       active,
   output logic       hsync,
   output logic       vsync,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_bad_timing
      $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
   end

   localparam coord_t H_ACT_C = coord_t'(H_ACTIVE);
   localparam coord_t V_ACT_C = coord_t'(V_ACTIVE);
   localparam coord_t HS_LO   = coord_t'(H_ACTIVE + H_FP);
   localparam coord_t HS_HI   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam coord_t VS_LO   = coord_t'(V_ACTIVE + V_FP);
   localparam coord_t VS_HI   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

   coord_t w_h;
   coord_t w_v;
   coord_t w_h_next;
   coord_t w_v_next;
   logic   w_h_wrap;
   logic   w_v_wrap;

   logic       r_active;
   logic       r_hsync;
   logic       r_vsync;
   logic       r_line_start;
   logic       r_frame_start;
   logic [7:0] r_frame_count;

   mod_counter #(
      .WIDTH     (CNT_W),
      .MODULUS   (H_TOTAL),
      .RESET_VAL (H_TOTAL - 1)
   ) u_hcnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (1'b1),
      .o_count (w_h),
      .o_next  (w_h_next),
      .o_wrap  (w_h_wrap)
   );

   mod_counter #(
      .WIDTH     (CNT_W),
      .MODULUS   (V_TOTAL),
      .RESET_VAL (V_TOTAL - 1)
   ) u_vcnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (w_h_wrap),
      .o_count (w_v),
      .o_next  (w_v_next),
      .o_wrap  (w_v_wrap)
   );

   // Register flag decodes of the next raster position; frame counter steps on raster wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_active      <= 1'b0;
         r_hsync       <= ~SYNC_ACTIVE;
         r_vsync       <= ~SYNC_ACTIVE;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_count <= 8'hFF;
      end else begin
         r_active      <= (w_h_next < H_ACT_C) && (w_v_next < V_ACT_C);
         r_hsync       <= in_window(w_h_next, HS_LO, HS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         r_vsync       <= in_window(w_v_next, VS_LO, VS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         r_line_start  <= (w_h_next == '0);
         r_frame_start <= (w_h_next == '0) && (w_v_next == '0);
         if (w_v_wrap) begin
            r_frame_count <= r_frame_count + 8'd1;
         end
      end
   end

   assign x           = w_h;
   assign y           = w_v;
   assign active      = r_active;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;
   assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a default 640x480 instance and a small
// active-high-sync instance, both checked against an arithmetic raster model.
module tb_vga_timing_gen;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       act;
      logic       hs;
      logic       vs;
      logic       ls;
      logic       fs;
      logic [7:0] fc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n_a = 1'b0;
   logic rst_n_b = 1'b0;

   logic [9:0] x_a, y_a, x_b, y_b;
   logic       act_a, hs_a, vs_a, ls_a, fs_a;
   logic       act_b, hs_b, vs_b, ls_b, fs_b;
   logic [7:0] fc_a, fc_b;
   exp_t       obs_a, obs_b;

   int n_checks = 0;
   int n_errors = 0;
   int na = -1;
   int nb = -1;

   always #5 clk = ~clk;

   vga_timing_gen u_dut_a (
      .clk(clk), .rst_n(rst_n_a), .x(x_a), .y(y_a), .active(act_a),
      .hsync(hs_a), .vsync(vs_a), .line_start(ls_a), .frame_start(fs_a),
      .frame_count(fc_a)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_ACTIVE(1'b1)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n_b), .x(x_b), .y(y_b), .active(act_b),
      .hsync(hs_b), .vsync(vs_b), .line_start(ls_b), .frame_start(fs_b),
      .frame_count(fc_b)
   );

   assign obs_a = {x_a, y_a, act_a, hs_a, vs_a, ls_a, fs_a, fc_a};
   assign obs_b = {x_b, y_b, act_b, hs_b, vs_b, ls_b, fs_b, fc_b};

   // n = edges since reset release minus one; n < 0 means held in reset
   function automatic exp_t ref_model(int n, int ha, int hfp, int hsw, int hbp,
                                      int va, int vfp, int vsw, int vbp, logic sa);
      exp_t e;
      int ht, vt, h, v, f;
      ht = ha + hfp + hsw + hbp;
      vt = va + vfp + vsw + vbp;
      if (n < 0) begin
         e.x = 10'(ht - 1); e.y = 10'(vt - 1);
         e.act = 1'b0; e.hs = ~sa; e.vs = ~sa;
         e.ls = 1'b0; e.fs = 1'b0; e.fc = 8'hFF;
         return e;
      end
      h = n % ht;
      v = (n / ht) % vt;
      f = n / (ht * vt);
      e.x   = 10'(h);
      e.y   = 10'(v);
      e.act = (h < ha) && (v < va);
      e.hs  = ((h >= ha + hfp) && (h < ha + hfp + hsw)) ? sa : ~sa;
      e.vs  = ((v >= va + vfp) && (v < va + vfp + vsw)) ? sa : ~sa;
      e.ls  = (h == 0);
      e.fs  = (h == 0) && (v == 0);
      e.fc  = 8'(f);
      return e;
   endfunction

   function automatic exp_t exp_a(int n);
      return ref_model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
   endfunction

   function automatic exp_t exp_b(int n);
      return ref_model(n, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1);
   endfunction

   task automatic test_reset();
      exp_t e;
      repeat (5) begin
         @(posedge clk); #1;
         e = exp_a(-1);
         n_checks++;
         if (obs_a !== e) begin
            n_errors++;
            $display("FAIL reset_hold_a got=%h exp=%h", obs_a, e);
         end
         e = exp_b(-1);
         n_checks++;
         if (obs_b !== e) begin
            n_errors++;
            $display("FAIL reset_hold_b got=%h exp=%h", obs_b, e);
         end
      end
      #2 rst_n_a = 1'b1;
      @(posedge clk); #1;
      na = 0;
      e = exp_a(na);
      n_checks++;
      if (obs_a !== e) begin
         n_errors++;
         $display("FAIL reset_release_a got=%h exp=%h", obs_a, e);
      end
   endtask

   task automatic test_line();
      exp_t e;
      int act_cnt, hs_cnt;
      act_cnt = act_a ? 1 : 0;
      hs_cnt  = (hs_a == 1'b0) ? 1 : 0;
      for (int i = 1; i < 802; i++) begin
         @(posedge clk); #1;
         na++;
         e = exp_a(na);
         n_checks++;
         if (obs_a !== e) begin
            n_errors++;
            $display("FAIL line_a n=%0d got=%h exp=%h", na, obs_a, e);
         end
         if (i < 800) begin
            if (act_a) act_cnt++;
            if (hs_a == 1'b0) hs_cnt++;
         end
      end
      n_checks++;
      if (act_cnt !== 640) begin
         n_errors++;
         $display("FAIL active_width got=%0d exp=640", act_cnt);
      end
      n_checks++;
      if (hs_cnt !== 96) begin
         n_errors++;
         $display("FAIL hsync_width got=%0d exp=96", hs_cnt);
      end
   endtask

   task automatic test_async_reset_a();
      exp_t e;
      int k, hold;
      for (int r = 0; r < 3; r++) begin
         k = $urandom_range(50, 3000);
         repeat (k) begin
            @(posedge clk); #1;
            na++;
            e = exp_a(na);
            n_checks++;
            if (obs_a !== e) begin
               n_errors++;
               $display("FAIL run_a n=%0d got=%h exp=%h", na, obs_a, e);
            end
         end
         #2 rst_n_a = 1'b0;
         #1;
         e = exp_a(-1);
         n_checks++;
         if (obs_a !== e) begin
            n_errors++;
            $display("FAIL async_reset_a got=%h exp=%h", obs_a, e);
         end
         hold = $urandom_range(1, 4);
         repeat (hold) begin
            @(posedge clk); #1;
            n_checks++;
            if (obs_a !== e) begin
               n_errors++;
               $display("FAIL reset_hold2_a got=%h exp=%h", obs_a, e);
            end
         end
         #2 rst_n_a = 1'b1;
         @(posedge clk); #1;
         na = 0;
         e = exp_a(na);
         n_checks++;
         if (obs_a !== e) begin
            n_errors++;
            $display("FAIL restart_a got=%h exp=%h", obs_a, e);
         end
      end
   endtask

   task automatic test_small_frames();
      exp_t e;
      int last_fs, vs_cnt, hs_cnt;
      #2 rst_n_b = 1'b1;
      @(posedge clk); #1;
      nb = 0;
      e = exp_b(nb);
      n_checks++;
      if (obs_b !== e) begin
         n_errors++;
         $display("FAIL release_b got=%h exp=%h", obs_b, e);
      end
      last_fs = 0;
      vs_cnt = vs_b ? 1 : 0;
      hs_cnt = hs_b ? 1 : 0;
      while (nb < 257 * 98 + 3) begin
         @(posedge clk); #1;
         nb++;
         e = exp_b(nb);
         n_checks++;
         if (obs_b !== e) begin
            n_errors++;
            $display("FAIL frames_b n=%0d got=%h exp=%h", nb, obs_b, e);
         end
         if (nb < 98) begin
            if (vs_b) vs_cnt++;
            if (hs_b) hs_cnt++;
         end
         if (fs_b) begin
            n_checks++;
            if (nb - last_fs !== 98) begin
               n_errors++;
               $display("FAIL frame_period got=%0d exp=98", nb - last_fs);
            end
            last_fs = nb;
         end
         if (nb == 256 * 98) begin
            n_checks++;
            if (fc_b !== 8'd0) begin
               n_errors++;
               $display("FAIL frame_count_wrap got=%0d exp=0", fc_b);
            end
         end
      end
      n_checks++;
      if (vs_cnt !== 14) begin
         n_errors++;
         $display("FAIL vsync_width_b got=%0d exp=14", vs_cnt);
      end
      n_checks++;
      if (hs_cnt !== 14) begin
         n_errors++;
         $display("FAIL hsync_count_b got=%0d exp=14", hs_cnt);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int k;
      for (int r = 0; r < 4; r++) begin
         k = $urandom_range(1, 400);
         repeat (k) begin
            @(posedge clk); #1;
            nb++;
            e = exp_b(nb);
            n_checks++;
            if (obs_b !== e) begin
               n_errors++;
               $display("FAIL b2b_run_b n=%0d got=%h exp=%h", nb, obs_b, e);
            end
         end
         #2 rst_n_b = 1'b0;
         #1;
         e = exp_b(-1);
         n_checks++;
         if (obs_b !== e) begin
            n_errors++;
            $display("FAIL b2b_reset_b got=%h exp=%h", obs_b, e);
         end
         @(posedge clk); #3 rst_n_b = 1'b1;
         @(posedge clk); #1;
         nb = 0;
         e = exp_b(nb);
         n_checks++;
         if (obs_b !== e) begin
            n_errors++;
            $display("FAIL b2b_restart_b got=%h exp=%h", obs_b, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_line();
      test_async_reset_a();
      test_small_frames();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
